fp_stream_capture: RTL and testbench

//  Receive end of the FP filter output stream. Takes IEEE-754 single-precision samples

---
 rtl/fp_stream_capture.sv | 110 +++++++++++
 tb/tb_fp_stream_capture.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_stream_capture.sv
// Receive-side FIFO for the FP filter output stream: conditions IEEE-754 single samples
// (subnormal flush, NaN/Inf flags), counts them and presents them first-word fall-through.
module fp_stream_capture #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [31:0]   data_in,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [AW:0]   level,
    output logic [31:0]   sample_cnt,
    output logic          overflow,
    output logic          nan_seen,
    output logic          inf_seen,
    input  logic          clr
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          full;
    logic          read;
    logic          write;
    logic          drop;
    logic [7:0]    exp_field;
    logic [22:0]   man_field;
    logic          is_subnormal;
    logic          is_nan;
    logic          is_inf;
    logic [31:0]   stored;

    assign exp_field    = data_in[30:23];
    assign man_field    = data_in[22:0];
    assign is_subnormal = (exp_field == 8'h00) && (man_field != 23'd0);
    assign is_nan       = (exp_field == 8'hFF) && (man_field != 23'd0);
    assign is_inf       = (exp_field == 8'hFF) && (man_field == 23'd0);
    assign stored       = is_subnormal ? {data_in[31], 31'd0} : data_in;

    // A full FIFO still takes a write when the head leaves on the same edge.
    assign full     = (level == FULL_LEVEL);
    assign rd_valid = (level != '0);
    assign read     = rd_valid && rd_ready;
    assign write    = valid_in && (!full || read);
    assign drop     = valid_in && full && !read;

    assign rd_data  = rd_valid ? mem[rd_ptr] : 32'h0;

    // Storage has no reset so it can map onto RAM; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= stored;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write, read})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // clr takes priority over any same-edge count or flag event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            overflow   <= 1'b0;
            nan_seen   <= 1'b0;
            inf_seen   <= 1'b0;
        end else if (clr) begin
            sample_cnt <= '0;
            overflow   <= 1'b0;
            nan_seen   <= 1'b0;
            inf_seen   <= 1'b0;
        end else begin
            if (write) begin
                sample_cnt <= sample_cnt + 32'd1;
                if (is_nan) begin
                    nan_seen <= 1'b1;
                end
                if (is_inf) begin
                    inf_seen <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_stream_capture.sv
// Self-checking bench for fp_stream_capture against a queue-based reference model.
module tb_fp_stream_capture;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [31:0]   data_in;
    logic          rd_ready;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic [AW:0]   level;
    logic [31:0]   sample_cnt;
    logic          overflow;
    logic          nan_seen;
    logic          inf_seen;
    logic          clr;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic [31:0] m_cnt;
    logic        m_ovf;
    logic        m_nan;
    logic        m_inf;

    fp_stream_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .level      (level),
        .sample_cnt (sample_cnt),
        .overflow   (overflow),
        .nan_seen   (nan_seen),
        .inf_seen   (inf_seen),
        .clr        (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_of(input logic [31:0] x);
        return int'((x >> 23) & 32'hFF);
    endfunction

    function automatic int man_of(input logic [31:0] x);
        return int'(x & 32'h7FFFFF);
    endfunction

    function automatic logic [31:0] cond_ref(input logic [31:0] x);
        if (exp_of(x) == 0 && man_of(x) != 0) return x & 32'h8000_0000;
        return x;
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return r & 32'h807F_FFFF;
            1:       return (r | 32'h7F80_0000) | 32'h0000_0001;
            2:       return (r & 32'h8000_0000) | 32'h7F80_0000;
            3:       return r & 32'h8000_0000;
            default: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
        endcase
    endfunction

    function automatic logic [31:0] head();
        if (mq.size() == 0) return 32'h0;
        return mq[0];
    endfunction

    // Advance one clock; the model applies the same inputs the DUT sees at the edge.
    task automatic tick();
        bit          rd;
        bit          wr;
        bit          drp;
        logic [31:0] w;
        logic [31:0] raw;
        raw = data_in;
        rd  = (mq.size() != 0) && rd_ready;
        wr  = valid_in && (mq.size() < DEPTH || rd);
        drp = valid_in && !wr;
        w   = cond_ref(raw);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0; m_ovf = 0; m_nan = 0; m_inf = 0;
            return;
        end
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(w);
        if (clr) begin
            m_cnt = 0; m_ovf = 0; m_nan = 0; m_inf = 0;
        end else begin
            if (wr) begin
                m_cnt = m_cnt + 1;
                if (exp_of(raw) == 255 && man_of(raw) != 0) m_nan = 1;
                if (exp_of(raw) == 255 && man_of(raw) == 0) m_inf = 1;
            end
            if (drp) m_ovf = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; rd_ready = 1'b0; clr = 1'b0;
        mq.delete();
        m_cnt = 0; m_ovf = 0; m_nan = 0; m_inf = 0;
        repeat (2) tick();
        checks++;
        if (rd_valid !== 1'b0 || level !== '0 || rd_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_fifo: rd_valid=%b level=%0d rd_data=%h, need 0/0/0",
                     rd_valid, level, rd_data);
        end
        checks++;
        if (sample_cnt !== 32'd0 || overflow !== 1'b0 || nan_seen !== 1'b0 || inf_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: cnt=%0d ovf=%b nan=%b inf=%b, need all 0",
                     sample_cnt, overflow, nan_seen, inf_seen);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'h3F80_0000;
        words[1] = 32'h4000_0000;
        words[2] = 32'hC040_0000;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            data_in  = words[i];
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== words[i]) begin
                errors++;
                $display("[TB] FAIL stream_word%0d: rd_valid=%b rd_data=%h, need 1/%h",
                         i, rd_valid, rd_data, words[i]);
            end
        end
        valid_in = 1'b0;
        tick();
        checks++;
        if (sample_cnt !== 32'd3 || level !== '0 || sample_cnt !== m_cnt) begin
            errors++;
            $display("[TB] FAIL stream_end: cnt=%0d level=%0d, need 3/0", sample_cnt, level);
        end
    endtask

    task automatic test_fill_overflow();
        rd_ready = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            valid_in = 1'b1;
            data_in  = 32'h3F80_0000 + 32'(i);
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if (level !== 7'(DEPTH) || overflow !== 1'b1 || sample_cnt !== 32'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL fill: level=%0d ovf=%b cnt=%0d, need %0d/1/%0d",
                     level, overflow, sample_cnt, DEPTH, DEPTH);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || level !== 7'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL clr_keeps_level: ovf=%b level=%0d, need 0/%0d",
                     overflow, level, DEPTH);
        end
    endtask

    task automatic test_full_read_write();
        logic [31:0] head_before;
        head_before = rd_data;
        checks++;
        if (head_before !== mq[0]) begin
            errors++;
            $display("[TB] FAIL full_head: rd_data=%h, need %h", head_before, mq[0]);
        end
        valid_in = 1'b1; rd_ready = 1'b1; data_in = 32'h4248_0000;
        tick();
        valid_in = 1'b0;
        checks++;
        if (level !== 7'(DEPTH) || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_rw: level=%0d ovf=%b, need %0d/0", level, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            checks++;
            if (rd_valid !== (mq.size() != 0) || rd_data !== head()) begin
                errors++;
                $display("[TB] FAIL drain%0d: rd_valid=%b rd_data=%h, need %b/%h",
                         i, rd_valid, rd_data, mq.size() != 0, head());
            end
            tick();
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("[TB] FAIL drain_empty: level=%0d, need 0", level);
        end
    endtask

    task automatic test_conditioning();
        logic [31:0] ins  [4];
        logic [31:0] outs [4];
        ins[0] = 32'h0000_0001; outs[0] = 32'h0000_0000;
        ins[1] = 32'h8040_0000; outs[1] = 32'h8000_0000;
        ins[2] = 32'h7FC0_0000; outs[2] = 32'h7FC0_0000;
        ins[3] = 32'hFF80_0000; outs[3] = 32'hFF80_0000;
        rd_ready = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = ins[i];
            tick();
            if (i == 1) begin
                checks++;
                if (nan_seen !== 1'b0 || inf_seen !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL subnormal_no_flag: nan=%b inf=%b, need 0/0", nan_seen, inf_seen);
                end
            end
        end
        valid_in = 1'b0;
        checks++;
        if (nan_seen !== 1'b1 || inf_seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL special_flags: nan=%b inf=%b, need 1/1", nan_seen, inf_seen);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data !== outs[i] || rd_data !== head()) begin
                errors++;
                $display("[TB] FAIL cond%0d: rd_data=%h, need %h", i, rd_data, outs[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_clr_with_nan();
        logic [AW:0] lvl_before;
        clr = 1'b1; tick(); clr = 1'b0;
        lvl_before = level;
        valid_in = 1'b1; data_in = 32'h7FC0_0001; clr = 1'b1;
        tick();
        valid_in = 1'b0; clr = 1'b0;
        checks++;
        if (nan_seen !== 1'b0 || sample_cnt !== 32'd0 || level !== lvl_before + 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_nan: nan=%b cnt=%0d level=%0d, need 0/0/%0d",
                     nan_seen, sample_cnt, level, lvl_before + 1'b1);
        end
        checks++;
        if (rd_data !== 32'h7FC0_0001) begin
            errors++;
            $display("[TB] FAIL clr_nan_data: rd_data=%h, need 7fc00001", rd_data);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            valid_in = ($urandom_range(0, 99) < 60);
            rd_ready = ($urandom_range(0, 99) < (i < 700 ? 40 : 65));
            data_in  = rand_sample();
            clr      = ($urandom_range(0, 99) < 3);
            tick();
            checks++;
            if (level !== 7'(mq.size()) || rd_valid !== (mq.size() != 0) || rd_data !== head()) begin
                errors++;
                $display("[TB] FAIL rand_fifo@%0d: level=%0d rd_valid=%b rd_data=%h, need %0d/%b/%h",
                         i, level, rd_valid, rd_data, mq.size(), mq.size() != 0, head());
            end
            checks++;
            if (sample_cnt !== m_cnt || overflow !== m_ovf || nan_seen !== m_nan || inf_seen !== m_inf) begin
                errors++;
                $display("[TB] FAIL rand_status@%0d: cnt=%0d ovf=%b nan=%b inf=%b, need %0d/%b/%b/%b",
                         i, sample_cnt, overflow, nan_seen, inf_seen, m_cnt, m_ovf, m_nan, m_inf);
            end
        end
        valid_in = 1'b0; rd_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b1;
        while (mq.size() != 0) tick();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            data_in  = (i == 4) ? 32'h7FC0_0000 : rand_sample() & 32'h7F7F_FFFF | 32'h0080_0000;
            tick();
        end
        valid_in = 1'b1; data_in = 32'h4000_0000;
        checks++;
        if (level !== 7'd10 || nan_seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: level=%0d nan=%b, need 10/1", level, nan_seen);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || level !== '0 || rd_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_fifo: rd_valid=%b level=%0d rd_data=%h, need 0/0/0",
                     rd_valid, level, rd_data);
        end
        checks++;
        if (nan_seen !== 1'b0 || inf_seen !== 1'b0 || overflow !== 1'b0 || sample_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_flags: nan=%b inf=%b ovf=%b cnt=%0d, need 0",
                     nan_seen, inf_seen, overflow, sample_cnt);
        end
        tick();
        rst_n = 1'b1;
        data_in = 32'h4140_0000;
        tick();
        valid_in = 1'b0;
        checks++;
        if (rd_data !== 32'h4140_0000 || level !== 7'd1 || sample_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL post_reset_first: rd_data=%h level=%0d cnt=%0d, need 41400000/1/1",
                     rd_data, level, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_overflow();
        test_full_read_write();
        test_conditioning();
        test_clr_with_nan();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
